// File: rtl/clint_timer.sv
// Machine timer / software-interrupt block on the core data bus.
// Holds a free-running 64-bit mtime, a 64-bit mtimecmp and the msip bit.
// It drives the core's timer and software interrupt lines.
// Zero-wait-state target: every request is accepted in the cycle it is presented.
// A read returns its data exactly one cycle after it is accepted.
//
// Handshake: a transfer happens on any clock edge where clint_req && clint_ready.
// clint_ready is constant 1, so back-to-back requests are accepted every cycle.
// A write has no response.
// A read raises clint_rvalid for one cycle on the following cycle, with clint_rdata valid.
// clint_rdata is 0 whenever clint_rvalid is 0.
// Only DW = 32 is supported.
module clint_timer #(
   parameter int AW       = 16,
   parameter int DW       = 32,
   parameter int PRESCALE = 1
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            clint_req,
   input  logic            clint_write,
   input  logic [DW/8-1:0] clint_wstrb,
   input  logic [AW-1:0]   clint_addr,
   input  logic [DW-1:0]   clint_wdata,
   output logic            clint_ready,
   output logic            clint_rvalid,
   output logic [DW-1:0]   clint_rdata,
   output logic            timer_interrupt,
   output logic            software_interrupt
);

   localparam logic [AW-1:0] ADDR_MSIP   = AW'(32'h0000_0000);
   localparam logic [AW-1:0] ADDR_CMP_LO = AW'(32'h0000_4000);
   localparam logic [AW-1:0] ADDR_CMP_HI = AW'(32'h0000_4004);
   localparam logic [AW-1:0] ADDR_MT_LO  = AW'(32'h0000_BFF8);
   localparam logic [AW-1:0] ADDR_MT_HI  = AW'(32'h0000_BFFC);
   localparam logic [15:0]   PCNT_MAX    = 16'(PRESCALE - 1);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic [15:0] pcnt;

   logic        tick;
   logic        wr_acc;
   logic        rd_acc;
   logic        sel_msip;
   logic        sel_cmp_lo;
   logic        sel_cmp_hi;
   logic        sel_mt_lo;
   logic        sel_mt_hi;
   logic [63:0] mtime_inc;
   logic [63:0] mtime_base;
   logic [63:0] mtime_next;
   logic [63:0] mtimecmp_next;
   logic        msip_next;
   logic [31:0] rd_val;
   logic        unused_addr_lsbs;

   // Replace only the byte lanes whose strobe is set.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return res;
   endfunction

   assign clint_ready        = 1'b1;
   assign software_interrupt = msip;

   // The two byte-offset bits never take part in decode.
   assign unused_addr_lsbs   = ^clint_addr[1:0];

   assign wr_acc     = clint_req && clint_ready && clint_write;
   assign rd_acc     = clint_req && clint_ready && !clint_write;
   assign sel_msip   = (clint_addr[AW-1:2] == ADDR_MSIP[AW-1:2]);
   assign sel_cmp_lo = (clint_addr[AW-1:2] == ADDR_CMP_LO[AW-1:2]);
   assign sel_cmp_hi = (clint_addr[AW-1:2] == ADDR_CMP_HI[AW-1:2]);
   assign sel_mt_lo  = (clint_addr[AW-1:2] == ADDR_MT_LO[AW-1:2]);
   assign sel_mt_hi  = (clint_addr[AW-1:2] == ADDR_MT_HI[AW-1:2]);
   assign tick       = (pcnt == PCNT_MAX);

   // Next-state for the timer registers.
   // Lanes that are not written keep the incremented value.
   // The carry into the high word always comes from the pre-write count.
   always_comb begin
      mtime_inc     = mtime + 64'd1;
      mtime_base    = tick ? mtime_inc : mtime;
      mtime_next    = mtime_base;
      mtimecmp_next = mtimecmp;
      msip_next     = msip;
      if (wr_acc) begin
         if (sel_mt_lo)  mtime_next[31:0]     = merge_lanes(mtime_base[31:0], clint_wdata, clint_wstrb);
         if (sel_mt_hi)  mtime_next[63:32]    = merge_lanes(mtime_base[63:32], clint_wdata, clint_wstrb);
         if (sel_cmp_lo) mtimecmp_next[31:0]  = merge_lanes(mtimecmp[31:0], clint_wdata, clint_wstrb);
         if (sel_cmp_hi) mtimecmp_next[63:32] = merge_lanes(mtimecmp[63:32], clint_wdata, clint_wstrb);
         if (sel_msip && clint_wstrb[0]) msip_next = clint_wdata[0];
      end
   end

   // Read mux on the current (pre-edge) register values.
   // Unmapped addresses read as zero.
   always_comb begin
      rd_val = 32'd0;
      if (sel_msip)   rd_val = {31'd0, msip};
      if (sel_cmp_lo) rd_val = mtimecmp[31:0];
      if (sel_cmp_hi) rd_val = mtimecmp[63:32];
      if (sel_mt_lo)  rd_val = mtime[31:0];
      if (sel_mt_hi)  rd_val = mtime[63:32];
   end

   // Prescaler: wraps after PRESCALE cycles; the wrap cycle is the mtime tick.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) pcnt <= 16'd0;
      else if (tick) pcnt <= 16'd0;
      else pcnt <= pcnt + 16'd1;
   end

   // Timer and software-interrupt registers.
   // The interrupt is compared on the post-edge values.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mtime           <= 64'd0;
         mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip            <= 1'b0;
         timer_interrupt <= 1'b0;
      end else begin
         mtime           <= mtime_next;
         mtimecmp        <= mtimecmp_next;
         msip            <= msip_next;
         timer_interrupt <= (mtime_next >= mtimecmp_next);
      end
   end

   // Read response: one cycle after acceptance; data is forced to zero when not valid.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         clint_rvalid <= 1'b0;
         clint_rdata  <= '0;
      end else if (rd_acc) begin
         clint_rvalid <= 1'b1;
         clint_rdata  <= rd_val;
      end else begin
         clint_rvalid <= 1'b0;
         clint_rdata  <= '0;
      end
   end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer.
// Two instances share one clock, reset and bus: u_dut1 with PRESCALE=1 and u_dut4 with PRESCALE=4.
// Each instance has its own request line.
module tb_clint_timer;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        req1, req4, wr;
   logic [3:0]  strb;
   logic [15:0] addr;
   logic [31:0] wdata;

   logic        ready1, rvalid1, tirq1, sirq1;
   logic [31:0] rdata1;
   logic        ready4, rvalid4, tirq4, sirq4;
   logic [31:0] rdata4;

   int tests = 0;
   int fails = 0;
   longint unsigned edges = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   // Posedges since reset release; with PRESCALE=1 and no mtime writes this equals mtime.
   always @(posedge clk) begin
      if (!rst_b) edges <= 0;
      else edges <= edges + 1;
   end

   clint_timer #(.AW(16), .DW(32), .PRESCALE(1)) u_dut1 (
      .clk(clk), .rst_b(rst_b), .clint_req(req1), .clint_write(wr),
      .clint_wstrb(strb), .clint_addr(addr), .clint_wdata(wdata),
      .clint_ready(ready1), .clint_rvalid(rvalid1), .clint_rdata(rdata1),
      .timer_interrupt(tirq1), .software_interrupt(sirq1)
   );

   clint_timer #(.AW(16), .DW(32), .PRESCALE(4)) u_dut4 (
      .clk(clk), .rst_b(rst_b), .clint_req(req4), .clint_write(wr),
      .clint_wstrb(strb), .clint_addr(addr), .clint_wdata(wdata),
      .clint_ready(ready4), .clint_rvalid(rvalid4), .clint_rdata(rdata4),
      .timer_interrupt(tirq4), .software_interrupt(sirq4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input bit sel, input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      @(negedge clk);
      addr = a; wdata = d; strb = s; wr = 1'b1;
      if (sel) req4 = 1'b1; else req1 = 1'b1;
      @(posedge clk); #1;
      req1 = 1'b0; req4 = 1'b0; wr = 1'b0;
      check("wr_no_rvalid", sel ? rvalid4 : rvalid1, 64'd0);
      check("wr_rdata_zero", sel ? rdata4 : rdata1, 64'd0);
   endtask

   // When use_model is set, the expected value is the edge count at drive time.
   task automatic bus_read(input bit sel, input logic [15:0] a, input logic [31:0] e,
                           input bit use_model, input string tag);
      logic [31:0] got;
      @(negedge clk);
      exp_q.push_back(use_model ? edges[31:0] : e);
      addr = a; wr = 1'b0;
      if (sel) req4 = 1'b1; else req1 = 1'b1;
      @(posedge clk); #1;
      req1 = 1'b0; req4 = 1'b0;
      check({tag, "_rvalid"}, sel ? rvalid4 : rvalid1, 64'd1);
      got = exp_q.pop_front();
      check(tag, sel ? rdata4 : rdata1, got);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      req1 = 0; req4 = 0; wr = 0; strb = 0; addr = 0; wdata = 0;
      #2;
      check("ready_in_reset", ready1, 64'd1);
      check("rvalid_reset", rvalid1, 64'd0);
      check("rdata_reset", rdata1, 64'd0);
      check("tirq_reset", tirq1, 64'd0);
      check("sirq_reset", sirq1, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_b = 1'b1;

      // Idle 10 cycles, then read mtime against the edge count.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("idle_tirq", tirq1, 64'd0);
      end
      bus_read(1'b0, 16'hBFF8, 32'd0, 1'b1, "mtime_lo_count");
      bus_read(1'b0, 16'hBFFC, 32'd0, 1'b0, "mtime_hi_zero");

      // Compare value of 20: the interrupt follows mtime >= 20 level-wise.
      bus_write(1'b0, 16'h4004, 32'd0, 4'hF);
      bus_write(1'b0, 16'h4000, 32'd20, 4'hF);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         check("tirq_level", tirq1, (edges >= 20) ? 64'd1 : 64'd0);
      end
      bus_write(1'b0, 16'h4004, 32'd1, 4'hF);
      check("tirq_fall", tirq1, 64'd0);
      bus_read(1'b0, 16'h4000, 32'd20, 1'b0, "cmp_lo");
      bus_read(1'b0, 16'h4004, 32'd1, 1'b0, "cmp_hi");
      bus_read(1'b0, 16'h4001, 32'd20, 1'b0, "cmp_lo_unaligned");

      // Low-word carry into the high word.
      bus_write(1'b0, 16'hBFFC, 32'd0, 4'hF);
      bus_write(1'b0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
      bus_read(1'b0, 16'hBFF8, 32'hFFFF_FFFF, 1'b0, "wrap_lo_pre");
      bus_read(1'b0, 16'hBFF8, 32'h0000_0000, 1'b0, "wrap_lo");
      bus_read(1'b0, 16'hBFFC, 32'h0000_0001, 1'b0, "wrap_hi");

      // Software interrupt and msip strobes.
      bus_write(1'b0, 16'h0000, 32'd1, 4'h1);
      check("sirq_set", sirq1, 64'd1);
      bus_write(1'b0, 16'h0000, 32'd0, 4'h0);
      check("sirq_nostrb", sirq1, 64'd1);
      bus_write(1'b0, 16'h0000, 32'd0, 4'hF);
      check("sirq_clr", sirq1, 64'd0);
      bus_read(1'b0, 16'h0000, 32'd0, 1'b0, "msip_read0");
      bus_write(1'b0, 16'h0000, 32'hFFFF_FFFF, 4'hF);
      check("sirq_set2", sirq1, 64'd1);
      bus_read(1'b0, 16'h0002, 32'd1, 1'b0, "msip_read1");

      // Unmapped address.
      bus_write(1'b0, 16'h1234, 32'hFFFF_FFFF, 4'hF);
      bus_read(1'b0, 16'h1234, 32'd0, 1'b0, "unmapped");

      // PRESCALE=4: partial-lane write on a tick cycle, then one increment per 4 cycles.
      bus_write(1'b1, 16'hBFF8, 32'hABCD_FFFF, 4'hF);
      while ((edges % 4) != 3) begin
         @(posedge clk); #1;
      end
      bus_write(1'b1, 16'hBFF8, 32'h0000_0100, 4'h3);
      bus_read(1'b1, 16'hBFF8, 32'hABCE_0100, 1'b0, "p4_lane");
      repeat (2) @(posedge clk);
      #1;
      bus_read(1'b1, 16'hBFF8, 32'hABCE_0100, 1'b0, "p4_hold");
      bus_read(1'b1, 16'hBFF8, 32'hABCE_0101, 1'b0, "p4_inc");
      bus_read(1'b1, 16'hBFFC, 32'd0, 1'b0, "p4_hi");

      // Reset while a read response is pending.
      check("tirq_before_reset", tirq1, 64'd1);
      @(negedge clk);
      addr = 16'h4004; wr = 1'b0; req1 = 1'b1;
      @(posedge clk); #1;
      req1 = 1'b0;
      check("rvalid_due", rvalid1, 64'd1);
      rst_b = 1'b0;
      #1;
      check("rst_rvalid", rvalid1, 64'd0);
      check("rst_rdata", rdata1, 64'd0);
      check("rst_tirq", tirq1, 64'd0);
      check("rst_sirq", sirq1, 64'd0);
      check("rst_ready", ready1, 64'd1);
      @(posedge clk);
      @(negedge clk); rst_b = 1'b1;
      @(posedge clk); #1;
      check("no_stale_rvalid", rvalid1, 64'd0);
      bus_read(1'b0, 16'h4000, 32'hFFFF_FFFF, 1'b0, "rst_cmp_lo");
      bus_read(1'b0, 16'h4004, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
      bus_read(1'b0, 16'h0000, 32'd0, 1'b0, "rst_msip");
      bus_read(1'b0, 16'hBFF8, 32'd0, 1'b1, "rst_mtime_lo");
      check("rst_tirq_after", tirq1, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
